// File: rtl/gelato_alu_dispatch.sv
`timescale 1ns/1ps
// gelato_alu_dispatch: queues ALU instructions, issues them one at a time to an
// external ALU, and returns each result to the register file over a
// valid/ready writeback port.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   rdy                   global enable; low freezes every register
//   inst_valid/inst_ready upstream handshake; inst_op, inst_rs1, inst_rs2, inst_rd_addr
//   alu_valid             task presented to the ALU; alu_op, alu_rs1, alu_rs2
//   alu_done, alu_rd      ALU result (level, valid while alu_done=1)
//   wb_valid/wb_ready     writeback handshake; wb_addr, wb_data
//   busy                  dispatcher active or queue non-empty
//   err_timeout           sticky: ALU did not answer within TIMEOUT_CYCLES
module gelato_alu_dispatch #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OP_WIDTH       = 4,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned QUEUE_DEPTH    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [OP_WIDTH-1:0]       inst_op,
    input  logic [DATA_WIDTH-1:0]     inst_rs1,
    input  logic [DATA_WIDTH-1:0]     inst_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] inst_rd_addr,
    output logic                      alu_valid,
    output logic [OP_WIDTH-1:0]       alu_op,
    output logic [DATA_WIDTH-1:0]     alu_rs1,
    output logic [DATA_WIDTH-1:0]     alu_rs2,
    input  logic                      alu_done,
    input  logic [DATA_WIDTH-1:0]     alu_rd,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [OP_WIDTH-1:0]       op;
        logic [DATA_WIDTH-1:0]     rs1;
        logic [DATA_WIDTH-1:0]     rs2;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WRITEBACK,
        S_DRAIN
    } state_t;

    state_t                    state;
    entry_t                    q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [TMO_W-1:0]          tmo_cnt;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    entry_t                    head;
    entry_t                    in_entry;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;

    // Queue status decodes straight from the occupancy register.
    assign full       = (count == CNT_W'(QUEUE_DEPTH));
    assign empty      = (count == '0);
    assign inst_ready = !full;
    assign busy       = (state != S_IDLE) || !empty;

    // A stale alu_done left over from the previous task blocks the next issue.
    assign push     = inst_valid && !full && rdy;
    assign pop      = rdy && (state == S_IDLE) && !empty && !alu_done;
    assign head     = q_mem[rd_ptr];
    assign in_entry = '{op: inst_op, rs1: inst_rs1, rs2: inst_rs2, rd_addr: inst_rd_addr};

    // Queue storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= in_entry;
        end
    end

    // Queue pointers, dispatcher FSM, task/writeback registers and timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tmo_cnt     <= '0;
            rd_addr_q   <= '0;
            alu_valid   <= 1'b0;
            alu_op      <= '0;
            alu_rs1     <= '0;
            alu_rs2     <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err_timeout <= 1'b0;
        end else if (rdy) begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        alu_op    <= head.op;
                        alu_rs1   <= head.rs1;
                        alu_rs2   <= head.rs2;
                        rd_addr_q <= head.rd_addr;
                        alu_valid <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_done) begin
                        wb_data   <= alu_rd;
                        wb_addr   <= rd_addr_q;
                        alu_valid <= 1'b0;
                        wb_valid  <= 1'b1;
                        state     <= S_WRITEBACK;
                    end else if (tmo_cnt < TMO_W'(TIMEOUT_CYCLES)) begin
                        // Flag raised on the same edge the counter saturates; no abort.
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // ALU lowers done only after seeing alu_valid low.
                    if (!alu_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gelato_alu_dispatch.sv
`timescale 1ns/1ps
// Bench for gelato_alu_dispatch: directed scenarios followed by a randomized
// run, all scored against an in-order writeback scoreboard and a simple
// behavioural ALU that answers with a programmable latency.
module tb_gelato_alu_dispatch;

    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = 4;
    localparam int unsigned RW  = 5;
    localparam int unsigned QD  = 2;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          inst_valid;
    logic          inst_ready;
    logic [OW-1:0] inst_op;
    logic [DW-1:0] inst_rs1;
    logic [DW-1:0] inst_rs2;
    logic [RW-1:0] inst_rd_addr;
    logic          alu_valid;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_rs1;
    logic [DW-1:0] alu_rs2;
    logic          alu_done;
    logic [DW-1:0] alu_rd;
    logic          wb_valid;
    logic          wb_ready;
    logic [RW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy;
    logic          err_timeout;

    gelato_alu_dispatch #(
        .DATA_WIDTH(DW), .OP_WIDTH(OW), .REG_ADDR_WIDTH(RW),
        .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
        .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .inst_rd_addr(inst_rd_addr),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_done(alu_done), .alu_rd(alu_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
    } iss_t;

    typedef struct packed {
        logic [RW-1:0] addr;
        logic [DW-1:0] data;
    } wbe_t;

    iss_t iss_q[$];
    wbe_t wb_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int n_wb    = 0;
    int n_push  = 0;
    bit last_push;
    bit prev_done_in;
    bit prev_valid;
    int alu_cnt;
    int alu_lat;
    int drain_hold;
    int drain_left;
    bit alu_hang;

    // Reference ALU behaviour; results are what the register file must receive.
    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes seen before the edge, then observe and react.
    task automatic step();
        bit   do_push;
        bit   do_wb;
        bit   in_rst;
        wbe_t e;
        iss_t s;
        do_push = rst_n && rdy && inst_valid && inst_ready;
        do_wb   = rst_n && rdy && wb_valid && wb_ready;
        in_rst  = !rst_n;
        if (do_push) begin
            iss_q.push_back('{op: inst_op, rs1: inst_rs1, rs2: inst_rs2});
            wb_q.push_back('{addr: inst_rd_addr, data: alu_fn(inst_op, inst_rs1, inst_rs2)});
            n_push++;
        end
        if (do_wb) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 64'd1, 64'd0);
            end else begin
                e = wb_q.pop_front();
                check("wb_addr", 64'(wb_addr), 64'(e.addr));
                check("wb_data", 64'(wb_data), 64'(e.data));
                n_wb++;
            end
        end
        prev_done_in = alu_done;
        prev_valid   = alu_valid;
        @(posedge clk);
        #1;
        last_push = do_push;
        if (in_rst) begin
            iss_q.delete();
            wb_q.delete();
        end
        if (alu_valid && !prev_valid) begin
            if (iss_q.size() == 0) begin
                check("issue_unexpected", 64'd1, 64'd0);
            end else begin
                s = iss_q.pop_front();
                check("issue_op",  64'(alu_op),  64'(s.op));
                check("issue_rs1", 64'(alu_rs1), 64'(s.rs1));
                check("issue_rs2", 64'(alu_rs2), 64'(s.rs2));
                check("issue_after_done_low", 64'(prev_done_in), 64'd0);
            end
        end
        // Behavioural ALU: done after alu_lat cycles of valid, optionally held after valid drops.
        if (!alu_valid) begin
            alu_cnt = 0;
            if (drain_left > 0) drain_left--;
            else alu_done = 1'b0;
        end else if (!alu_hang) begin
            if (alu_cnt >= alu_lat) begin
                alu_done   = 1'b1;
                alu_rd     = alu_fn(alu_op, alu_rs1, alu_rs2);
                drain_left = drain_hold;
            end else begin
                alu_cnt++;
            end
        end
    endtask

    task automatic push_inst(input logic [OW-1:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [RW-1:0] rd);
        inst_valid   = 1'b1;
        inst_op      = op;
        inst_rs1     = a;
        inst_rs2     = b;
        inst_rd_addr = rd;
        for (int i = 0; i < 200; i++) begin
            step();
            if (last_push) break;
        end
        inst_valid = 1'b0;
        if (!last_push) check("push_accept", 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (alu_valid) break;
            step();
        end
        check(tag, 64'(alu_valid), 64'd1);
    endtask

    task automatic wait_wb(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (wb_valid) break;
            step();
        end
        check(tag, 64'(wb_valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        rdy      = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!busy && !wb_valid && wb_q.size() == 0) break;
            step();
        end
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pending"}, 64'(wb_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst_ready"}, 64'(inst_ready), 64'd1);
        check({tag, "_alu_valid"}, 64'(alu_valid), 64'd0);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err_timeout), 64'd0);
        check({tag, "_alu_op"}, 64'(alu_op), 64'd0);
        check({tag, "_alu_rs1"}, 64'(alu_rs1), 64'd0);
        check({tag, "_alu_rs2"}, 64'(alu_rs2), 64'd0);
        check({tag, "_wb_addr"}, 64'(wb_addr), 64'd0);
        check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   wb0;
        logic [OW-1:0] w_op;
        logic [DW-1:0] w_a;
        logic [DW-1:0] w_b;
        wbe_t exp_wb;

        rst_n = 1'b0; rdy = 1'b1; inst_valid = 1'b0;
        inst_op = '0; inst_rs1 = '0; inst_rs2 = '0; inst_rd_addr = '0;
        alu_done = 1'b0; alu_rd = '0; wb_ready = 1'b1;
        alu_cnt = 0; alu_lat = 1; drain_hold = 0; drain_left = 0; alu_hang = 1'b0;
        prev_done_in = 1'b0; prev_valid = 1'b0; last_push = 1'b0;

        // Reset state.
        step(); step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single ADD with minimum latency: push N, alu_valid N+2, done one cycle later.
        wb0 = n_wb;
        push_inst(4'd0, 32'd5, 32'd7, 5'd3);
        check("add_lat_n1", 64'(alu_valid), 64'd0);
        step();
        check("add_lat_n2", 64'(alu_valid), 64'd1);
        step(); step();
        check("add_wb_valid", 64'(wb_valid), 64'd1);
        check("add_wb_addr", 64'(wb_addr), 64'd3);
        check("add_wb_data", 64'(wb_data), 64'd12);
        check("add_alu_dropped", 64'(alu_valid), 64'd0);
        repeat (6) step();
        check("add_one_wb", 64'(n_wb - wb0), 64'd1);

        // Back-pressure: three back-to-back pushes against a stalled ALU.
        alu_lat = 12;
        wb0 = n_wb;
        push_inst(4'd1, 32'd100, 32'd1, 5'd10);
        push_inst(4'd2, 32'hF0F0, 32'h0FF0, 5'd11);
        push_inst(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd12);
        check("bp_full_ready", 64'(inst_ready), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        alu_lat = 1;
        wait_idle("bp_idle");
        check("bp_three_wb", 64'(n_wb - wb0), 64'd3);

        // Writeback stall for 5 cycles; ALU holds done into DRAIN.
        wb_ready = 1'b0; alu_lat = 0; drain_hold = 12;
        wb0 = n_wb;
        push_inst(4'd3, 32'h1234_0000, 32'h0000_5678, 5'd20);
        push_inst(4'd0, 32'hFFFF_FFFF, 32'd2, 5'd21);
        wait_wb("hold_wb_seen");
        exp_wb = wb_q[0];
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_wb_valid", 64'(wb_valid), 64'd1);
            check("hold_wb_addr", 64'(wb_addr), 64'(exp_wb.addr));
            check("hold_wb_data", 64'(wb_data), 64'(exp_wb.data));
            check("hold_alu_valid", 64'(alu_valid), 64'd0);
        end
        wait_idle("hold_idle");
        check("hold_two_wb", 64'(n_wb - wb0), 64'd2);
        drain_hold = 0;

        // Stale alu_done while idle must not let an instruction issue.
        alu_lat = 1;
        alu_done = 1'b1; drain_left = 6;
        push_inst(4'd2, 32'hDEAD_BEEF, 32'hFFFF_0000, 5'd7);
        step();
        check("stale_no_issue", 64'(alu_valid), 64'd0);
        step();
        check("stale_no_issue2", 64'(alu_valid), 64'd0);
        wait_idle("stale_idle");

        // rdy low for 4 cycles mid-ISSUE while ALU answers and upstream offers data.
        alu_lat = 2;
        wb0 = n_wb;
        w_op = 4'd1; w_a = 32'd1000; w_b = 32'd1;
        push_inst(w_op, w_a, w_b, 5'd9);
        wait_valid("frz_issue");
        rdy = 1'b0;
        inst_valid = 1'b1; inst_op = 4'd4; inst_rs1 = 32'h3; inst_rs2 = 32'h5; inst_rd_addr = 5'd30;
        for (int i = 0; i < 4; i++) begin
            step();
            check("frz_alu_valid", 64'(alu_valid), 64'd1);
            check("frz_alu_op", 64'(alu_op), 64'(w_op));
            check("frz_alu_rs1", 64'(alu_rs1), 64'(w_a));
            check("frz_wb_valid", 64'(wb_valid), 64'd0);
            check("frz_inst_ready", 64'(inst_ready), 64'd1);
            check("frz_no_push", 64'(last_push), 64'd0);
        end
        rdy = 1'b1;
        step();
        inst_valid = 1'b0;
        check("frz_resume_wb", 64'(wb_valid), 64'd1);
        check("frz_resume_push", 64'(last_push), 64'd1);
        wait_idle("frz_idle");
        check("frz_two_wb", 64'(n_wb - wb0), 64'd2);

        // ALU never answers: sticky timeout exactly TMO enabled cycles after ISSUE entry.
        alu_hang = 1'b1;
        push_inst(4'd0, 32'd1, 32'd1, 5'd1);
        wait_valid("tmo_issue");
        repeat (TMO - 1) step();
        check("tmo_early", 64'(err_timeout), 64'd0);
        step();
        check("tmo_set", 64'(err_timeout), 64'd1);
        check("tmo_still_issue", 64'(alu_valid), 64'd1);
        repeat (5) step();
        check("tmo_sticky", 64'(err_timeout), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        alu_hang = 1'b0;
        check("tmo_cleared", 64'(err_timeout), 64'd0);
        step();

        // Reset during WRITEBACK with one queued: everything discarded.
        wb_ready = 1'b0; alu_lat = 0;
        push_inst(4'd3, 32'h11, 32'h22, 5'd4);
        push_inst(4'd4, 32'h33, 32'h44, 5'd5);
        wait_wb("rstwb_in_wb");
        rst_n = 1'b0;
        step();
        check_reset_outputs("rstwb");
        rst_n = 1'b1;
        wb_ready = 1'b1;
        wb0 = n_wb;
        repeat (20) step();
        check("rstwb_no_wb", 64'(n_wb - wb0), 64'd0);
        check("rstwb_idle", 64'(busy), 64'd0);

        // Randomized traffic against the scoreboard.
        n_push = 0;
        wb0 = n_wb;
        for (int c = 0; c < 2000; c++) begin
            rdy        = ($urandom_range(0, 9) != 0);
            wb_ready   = ($urandom_range(0, 2) != 0);
            alu_lat    = int'($urandom_range(0, 3));
            drain_hold = int'($urandom_range(0, 2));
            if (!inst_valid && $urandom_range(0, 1) == 1) begin
                inst_valid   = 1'b1;
                inst_op      = OW'($urandom_range(0, 6));
                inst_rs1     = $urandom;
                inst_rs2     = $urandom;
                inst_rd_addr = RW'($urandom);
            end
            step();
            if (last_push) inst_valid = 1'b0;
        end
        inst_valid = 1'b0;
        drain_hold = 0;
        wait_idle("rand_idle");
        check("rand_all_written", 64'(n_wb - wb0), 64'(n_push));
        check("rand_issue_q_empty", 64'(iss_q.size()), 64'd0);
        check("rand_no_timeout", 64'(err_timeout), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
